rr_arbiter: RTL

Round-robin arbiter that shares one `req`/`gnt` resource among `N` requesters. Each requester raises a `req` bit and holds it for as long as it needs the resource. The arbiter issues a one-hot registered grant and holds it until that requester drops its request, optionally enforcing a maximum hold time. The arbiter sits in front of the single-requester resource. Its `gnt` vector and `busy` flag drive the resource's `req` input and are checked by a bound property module.

---
 rtl/rr_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter_pick.sv | 39 +++
 rtl/rr_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and default parameters for the round-robin arbiter.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_N_DEF        = 4;
  localparam int unsigned ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_pick: combinational round-robin selector. Rotates req down by ptr using a
// double-width copy, priority-encodes the lowest set bit, then rotates back.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N = ARB_N_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned PW = $clog2(N);
  localparam logic [PW:0] NV = (PW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = '0;
    // Scan from the top so the lowest set bit is the one left standing.
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) begin
        found = 1'b1;
        off   = PW'(i - 1);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Optional forced revocation after MAX_HOLD cycles: define RR_ARBITER_TIMEOUT_EN.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N        = ARB_N_DEF,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 timeout
);

  localparam int unsigned PW = $clog2(N);

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
  end

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          found;
  logic [PW-1:0] win;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win;
          owner_d = win;
          busy_d  = 1'b1;
          ptr_d   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
`ifdef RR_ARBITER_TIMEOUT_EN
          cnt_d = CW'(1);
`endif
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          owner_d = '0;
          busy_d  = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
          cnt_d = '0;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          owner_d   = '0;
          busy_d    = 1'b0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
`ifdef RR_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign owner = owner_q;
`ifdef RR_ARBITER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
